// File: rtl/fifo_based_on_ram_prefetch.sv
// FIFO controller for an external simple-dual-port RAM. A small credit-based
// prefetch buffer hides the RAM read latency in both FWFT and standard modes.
module fifo_based_on_ram_prefetch #(
  parameter string fwft_mode        = "true",
  parameter int    ram_read_la      = 1,
  parameter int    fifo_depth       = 32,
  parameter int    fifo_data_width  = 32,
  parameter int    simulation_delay = 1,
  localparam int   AW = $clog2(fifo_depth),
  localparam int   CW = $clog2(fifo_depth) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fifo_flush,
  input  logic                       fifo_wen,
  input  logic [fifo_data_width-1:0] fifo_din,
  output logic                       fifo_full,
  output logic                       fifo_full_n,
  output logic                       fifo_almost_full,
  output logic                       fifo_almost_full_n,
  input  logic                       fifo_ren,
  output logic [fifo_data_width-1:0] fifo_dout,
  output logic                       fifo_empty,
  output logic                       fifo_empty_n,
  output logic                       fifo_almost_empty,
  output logic                       fifo_almost_empty_n,
  input  logic [CW-1:0]              almost_full_th,
  input  logic [CW-1:0]              almost_empty_th,
  output logic                       ram_wen,
  output logic [AW-1:0]              ram_w_addr,
  output logic [fifo_data_width-1:0] ram_din,
  output logic                       ram_ren,
  output logic [AW-1:0]              ram_r_addr,
  input  logic [fifo_data_width-1:0] ram_dout,
  output logic                       overflow,
  output logic                       underflow,
  output logic [CW-1:0]              data_cnt
);

  localparam bit              FWFT    = (fwft_mode == "true");
  localparam int              LA      = ram_read_la;
  localparam int              PB      = ram_read_la + 1;
  localparam int              IW      = $clog2(PB);
  localparam logic [IW-1:0]   PB_LAST = IW'(PB - 1);
  localparam logic [2:0]      PB_W    = 3'(PB);
  localparam logic [CW-1:0]   DEPTH   = CW'(fifo_depth);
  localparam logic [AW:0]     PTR_ONE = 1;
  localparam logic [CW-1:0]   CNT_ONE = 1;

  logic [AW:0]                wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [LA-1:0]              tag_q, tag_d;
  logic [fifo_data_width-1:0] pbuf_q [PB];
  logic [IW-1:0]              pb_rd_q, pb_rd_d, pb_wr_q, pb_wr_d;
  logic [1:0]                 pb_cnt_q, pb_cnt_d;
  logic                       ovf_q, ovf_d, unf_q, unf_d;
  logic                       wr_acc, rd_acc, push, empty_n;
  logic [2:0]                 in_flight, credit_used;
  logic                       unused_sim_delay;

  assign unused_sim_delay = (simulation_delay != 0);

  function automatic logic [IW-1:0] pb_inc(input logic [IW-1:0] idx);
    return (idx == PB_LAST) ? '0 : idx + IW'(1);
  endfunction

  assign empty_n = (pb_cnt_q != 2'd0);
  assign wr_acc  = fifo_wen & ~fifo_full & ~fifo_flush;
  assign rd_acc  = fifo_ren & empty_n & ~fifo_flush;
  assign push    = tag_q[LA-1];

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < LA; i++) in_flight = in_flight + {2'b00, tag_q[i]};
  end

  // A read popping this cycle frees its slot, which keeps 1 word/clk streaming.
  assign credit_used = in_flight + {1'b0, pb_cnt_q} - {2'b00, rd_acc};
  assign ram_ren     = (wptr_q != rptr_q) & (credit_used < PB_W) & ~fifo_flush;

  assign ram_wen    = wr_acc;
  assign ram_w_addr = wptr_q[AW-1:0];
  assign ram_din    = fifo_din;
  assign ram_r_addr = rptr_q[AW-1:0];

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    pb_rd_d  = pb_rd_q;
    pb_wr_d  = pb_wr_q;
    pb_cnt_d = pb_cnt_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (fifo_flush) begin
      wptr_d   = '0;
      rptr_d   = '0;
      cnt_d    = '0;
      tag_d    = '0;
      pb_rd_d  = '0;
      pb_wr_d  = '0;
      pb_cnt_d = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc)  wptr_d = wptr_q + PTR_ONE;
      if (ram_ren) rptr_d = rptr_q + PTR_ONE;
      if (wr_acc && !rd_acc)      cnt_d = cnt_q + CNT_ONE;
      else if (!wr_acc && rd_acc) cnt_d = cnt_q - CNT_ONE;
      tag_d[0] = ram_ren;
      for (int i = 1; i < LA; i++) tag_d[i] = tag_q[i-1];
      if (push)   pb_wr_d = pb_inc(pb_wr_q);
      if (rd_acc) pb_rd_d = pb_inc(pb_rd_q);
      pb_cnt_d = pb_cnt_q + {1'b0, push} - {1'b0, rd_acc};
      ovf_d    = ovf_q | (fifo_wen & fifo_full);
      unf_d    = unf_q | (fifo_ren & ~empty_n);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      tag_q    <= '0;
      pb_rd_q  <= '0;
      pb_wr_q  <= '0;
      pb_cnt_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      tag_q    <= tag_d;
      pb_rd_q  <= pb_rd_d;
      pb_wr_q  <= pb_wr_d;
      pb_cnt_q <= pb_cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PB; i++) pbuf_q[i] <= '0;
    end else if (push && !fifo_flush) begin
      pbuf_q[pb_wr_q] <= ram_dout;
    end
  end

  if (FWFT) begin : g_fwft
    assign fifo_dout = pbuf_q[pb_rd_q];
  end else begin : g_std
    logic [fifo_data_width-1:0] dout_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      dout_q <= '0;
      else if (rd_acc) dout_q <= pbuf_q[pb_rd_q];
    end
    assign fifo_dout = dout_q;
  end

  assign data_cnt            = cnt_q;
  assign fifo_full           = (cnt_q == DEPTH);
  assign fifo_full_n         = ~fifo_full;
  assign fifo_empty_n        = empty_n;
  assign fifo_empty          = ~empty_n;
  assign fifo_almost_full    = (cnt_q >= almost_full_th);
  assign fifo_almost_full_n  = ~fifo_almost_full;
  assign fifo_almost_empty   = (cnt_q <= almost_empty_th);
  assign fifo_almost_empty_n = ~fifo_almost_empty;
  assign overflow            = ovf_q;
  assign underflow           = unf_q;

endmodule

// File: tb/tb_fifo_based_on_ram_prefetch.sv
// Random-stimulus bench: four FIFO instances (FWFT/standard x latency 1/2) share
// one stimulus stream, each checked against a queue-level reference model.
module tb_fifo_based_on_ram_prefetch;

  localparam int DEPTH = 16;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int CW    = 5;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          wen   = 1'b0;
  logic          ren   = 1'b0;
  logic [DW-1:0] din   = '0;
  logic [CW-1:0] af_th = 5'd12;
  logic [CW-1:0] ae_th = 5'd3;
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam string FM = (g < 2) ? "true" : "false";
    localparam bit    MF = (g < 2);
    localparam int    ML = (g % 2) + 1;

    logic          full, full_n, afull, afull_n, empty, empty_n, aempty, aempty_n;
    logic          r_wen, r_ren, ov, uf;
    logic [AW-1:0] r_waddr, r_raddr;
    logic [DW-1:0] dout, r_din, r_dout, s1, s2;
    logic [CW-1:0] cnt;
    logic [DW-1:0] mem [DEPTH];

    fifo_based_on_ram_prefetch #(
      .fwft_mode(FM), .ram_read_la(ML), .fifo_depth(DEPTH),
      .fifo_data_width(DW), .simulation_delay(1)
    ) dut (
      .clk(clk), .rst_n(rst_n), .fifo_flush(flush),
      .fifo_wen(wen), .fifo_din(din),
      .fifo_full(full), .fifo_full_n(full_n),
      .fifo_almost_full(afull), .fifo_almost_full_n(afull_n),
      .fifo_ren(ren), .fifo_dout(dout),
      .fifo_empty(empty), .fifo_empty_n(empty_n),
      .fifo_almost_empty(aempty), .fifo_almost_empty_n(aempty_n),
      .almost_full_th(af_th), .almost_empty_th(ae_th),
      .ram_wen(r_wen), .ram_w_addr(r_waddr), .ram_din(r_din),
      .ram_ren(r_ren), .ram_r_addr(r_raddr), .ram_dout(r_dout),
      .overflow(ov), .underflow(uf), .data_cnt(cnt)
    );

    always @(posedge clk) begin
      if (r_wen) mem[r_waddr] <= r_din;
      if (r_ren) s1 <= mem[r_raddr];
      s2 <= s1;
    end
    assign r_dout = (ML == 1) ? s1 : s2;

    // Reference: words sit in RAM, then in flight (visible la+1 cycles after
    // fetch), then in a readable buffer limited to la+1 words incl. in-flight.
    logic [DW-1:0] q_ram[$];
    logic [DW-1:0] q_fly[$];
    logic [DW-1:0] q_buf[$];
    int            t_fly[$];
    int            cyc  = 0;
    int            wp   = 0;
    int            rp   = 0;
    bit            m_ov = 0;
    bit            m_uf = 0;
    logic [DW-1:0] m_dout = '0;

    always @(negedge clk) begin : model
      int            tot;
      bit            e_full, e_ne, acc_w, acc_r, fetch;
      logic [DW-1:0] e_dout;
      cyc++;
      if (!rst_n) begin
        q_ram.delete(); q_fly.delete(); q_buf.delete(); t_fly.delete();
        wp = 0; rp = 0; m_ov = 0; m_uf = 0; m_dout = '0;
      end
      tot    = q_ram.size() + q_fly.size() + q_buf.size();
      e_full = (tot == DEPTH);
      e_ne   = (q_buf.size() > 0);
      acc_w  = rst_n && wen && !e_full && !flush;
      acc_r  = rst_n && ren && e_ne && !flush;
      fetch  = rst_n && (q_ram.size() > 0) && !flush &&
               (q_fly.size() + q_buf.size() - int'(acc_r) < ML + 1);

      chk($sformatf("i%0d_flags", g),
          {full, full_n, empty, empty_n, afull, afull_n, aempty, aempty_n, ov, uf},
          {e_full, !e_full, !e_ne, e_ne, tot >= int'(af_th), tot < int'(af_th),
           tot <= int'(ae_th), tot > int'(ae_th), m_ov, m_uf});
      chk($sformatf("i%0d_cnt", g), cnt, tot);
      chk($sformatf("i%0d_ram_en", g), {r_wen, r_ren}, {acc_w, fetch});
      if (acc_w) chk($sformatf("i%0d_waddr_din", g), {r_waddr, r_din}, {4'(wp % DEPTH), din});
      if (fetch) chk($sformatf("i%0d_raddr", g), r_raddr, rp % DEPTH);
      e_dout = MF ? (e_ne ? q_buf[0] : '0) : m_dout;
      if (!MF || e_ne || !rst_n) chk($sformatf("i%0d_dout", g), dout, e_dout);

      if (rst_n) begin
        if (flush) begin
          q_ram.delete(); q_fly.delete(); q_buf.delete(); t_fly.delete();
          wp = 0; rp = 0; m_ov = 0; m_uf = 0;
        end else begin
          if (wen && e_full) m_ov = 1;
          if (ren && !e_ne)  m_uf = 1;
          if (acc_r) m_dout = q_buf.pop_front();
          while (t_fly.size() > 0 && t_fly[0] <= cyc + 1) begin
            q_buf.push_back(q_fly.pop_front());
            void'(t_fly.pop_front());
          end
          if (fetch) begin
            q_fly.push_back(q_ram.pop_front());
            t_fly.push_back(cyc + ML + 1);
            rp = (rp + 1) % (2 * DEPTH);
          end
          if (acc_w) begin
            q_ram.push_back(din);
            wp = (wp + 1) % (2 * DEPTH);
          end
        end
      end
    end
  end

  task automatic run(input int n, input int pw, input int pr, input int pf);
    for (int i = 0; i < n; i++) begin
      wen   = ($urandom_range(0, 99) < pw);
      ren   = ($urandom_range(0, 99) < pr);
      flush = ($urandom_range(0, 99) < pf);
      din   = DW'($urandom);
      if ($urandom_range(0, 9) == 0) af_th = CW'($urandom_range(1, DEPTH - 1));
      if ($urandom_range(0, 9) == 0) ae_th = CW'($urandom_range(1, DEPTH - 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset(input int n);
    wen = 0; ren = 0; flush = 0;
    rst_n = 0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    pulse_reset(3);
    run(60, 90, 10, 0);
    run(60, 10, 90, 0);
    run(80, 100, 100, 0);
    run(150, 60, 60, 3);
    run(20, 100, 20, 0);
    pulse_reset(2);
    run(60, 95, 5, 0);
    run(40, 100, 100, 0);
    run(150, 50, 50, 4);
    run(40, 5, 95, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
